// File: rtl/jk_latch_exerciser.sv
// Self-test sequencer for a JK latch: drives a fixed 7-step J/K/EN pattern, checks Q/Qn
// against an internal JK reference model and keeps a saturating mismatch count.
module jk_latch_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             q_i,
    input  logic             qn_i,
    output logic             j_o,
    output logic             k_o,
    output logic             en_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       step_idx,
    output logic             mismatch
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned LAST_STEP = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ENABLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // Step table entry packed as {EN, J, K}
    function automatic logic [2:0] step_vec(input logic [STEP_W-1:0] idx);
        logic [2:0] v;
        case (idx)
            3'd1:    v = 3'b100;
            3'd2:    v = 3'b110;
            3'd3:    v = 3'b101;
            3'd4:    v = 3'b111;
            3'd5:    v = 3'b111;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    state_t            state_q, state_d;
    logic              start_q;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              exp_q, exp_d;
    logic              valid_q, valid_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              j_q, j_d, k_q, k_d, en_q, en_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              mismatch_q, mismatch_d;
    logic [2:0]        vec_cur, vec_nxt;

    // Next-state, reference model and check; outputs are decoded from the next state
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        valid_d    = valid_q;
        err_d      = err_q;
        mismatch_d = 1'b0;
        vec_cur    = step_vec(step_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_q) begin
                    state_d = S_SETUP;
                    step_d  = '0;
                    exp_d   = 1'b0;
                    valid_d = 1'b0;
                    err_d   = '0;
                end
            end
            S_SETUP: state_d = S_ENABLE;
            S_ENABLE: begin
                state_d = S_SETTLE;
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                if (vec_cur[2]) begin
                    case (vec_cur[1:0])
                        2'b10: begin exp_d = 1'b1; valid_d = 1'b1; end
                        2'b01: begin exp_d = 1'b0; valid_d = 1'b1; end
                        2'b11: if (valid_q) exp_d = ~exp_q;
                        default: ;
                    endcase
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                    // Q/Qn are sampled at the end of the last settle cycle so the result shows in CHECK
                    if (valid_q && ((q_i != exp_q) || (qn_i == q_i))) begin
                        mismatch_d = 1'b1;
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (step_q == STEP_W'(LAST_STEP)) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        vec_nxt = step_vec(step_d);
        busy_d  = (state_d == S_SETUP) || (state_d == S_ENABLE) ||
                  (state_d == S_SETTLE) || (state_d == S_CHECK);
        j_d     = busy_d & vec_nxt[1];
        k_d     = busy_d & vec_nxt[0];
        en_d    = (state_d == S_ENABLE) & vec_nxt[2];
        done_d  = (state_d == S_DONE);
        pass_d  = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            step_q     <= '0;
            cnt_q      <= '0;
            exp_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= '0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            j_q        <= j_d;
            k_q        <= k_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign j_o       = j_q;
    assign k_o       = k_q;
    assign en_o      = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign step_idx  = step_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_jk_latch_exerciser.sv
// Directed bench: three exercisers (default, ERR_W=2, SETTLE_CYCLES=1) each driving a JK latch model with injectable faults.
module tb_jk_latch_exerciser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] fault;    // 0 good, 1 Q stuck-at-0, 2 Qn tied to Q

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // DUT A: default parameters
    logic       q_a, qn_a, ql_a = 1'b0;
    logic       j_a, k_a, en_a, busy_a, done_a, pass_a, mm_a;
    logic [7:0] err_a;
    logic [2:0] step_a;

    jk_latch_exerciser dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .q_i(q_a), .qn_i(qn_a),
        .j_o(j_a), .k_o(k_a), .en_o(en_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .step_idx(step_a), .mismatch(mm_a)
    );

    // DUT B: 2-bit saturating error counter
    logic       q_b, qn_b, ql_b = 1'b0;
    logic       j_b, k_b, en_b, busy_b, done_b, pass_b, mm_b;
    logic [1:0] err_b;
    logic [2:0] step_b;

    jk_latch_exerciser #(.ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .q_i(q_b), .qn_i(qn_b),
        .j_o(j_b), .k_o(k_b), .en_o(en_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .step_idx(step_b), .mismatch(mm_b)
    );

    // DUT C: single settle cycle
    logic       q_c, qn_c, ql_c = 1'b0;
    logic       j_c, k_c, en_c, busy_c, done_c, pass_c, mm_c;
    logic [7:0] err_c;
    logic [2:0] step_c;

    jk_latch_exerciser #(.SETTLE_CYCLES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .q_i(q_c), .qn_i(qn_c),
        .j_o(j_c), .k_o(k_c), .en_o(en_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .step_idx(step_c), .mismatch(mm_c)
    );

    // JK latch models: one state change per EN pulse
    always @(posedge clk) if (en_a) case ({j_a, k_a})
        2'b10: ql_a <= 1'b1;  2'b01: ql_a <= 1'b0;  2'b11: ql_a <= ~ql_a;  default: ;
    endcase
    always @(posedge clk) if (en_b) case ({j_b, k_b})
        2'b10: ql_b <= 1'b1;  2'b01: ql_b <= 1'b0;  2'b11: ql_b <= ~ql_b;  default: ;
    endcase
    always @(posedge clk) if (en_c) case ({j_c, k_c})
        2'b10: ql_c <= 1'b1;  2'b01: ql_c <= 1'b0;  2'b11: ql_c <= ~ql_c;  default: ;
    endcase

    assign q_a  = (fault == 2'd1) ? 1'b0 : ql_a;
    assign qn_a = (fault == 2'd2) ? q_a  : ~q_a;
    assign q_b  = (fault == 2'd1) ? 1'b0 : ql_b;
    assign qn_b = (fault == 2'd2) ? q_b  : ~q_b;
    assign q_c  = (fault == 2'd1) ? 1'b0 : ql_c;
    assign qn_c = (fault == 2'd2) ? q_c  : ~q_c;

    // Activity monitors sampled on the falling edge
    int  mm_cnt_a = 0;
    int  en_cnt_c = 0;
    int  jk_viol_c = 0;
    logic pj_c = 1'b0, pk_c = 1'b0;

    always @(negedge clk) begin
        if (mm_a) mm_cnt_a <= mm_cnt_a + 1;
        if (en_c) en_cnt_c <= en_cnt_c + 1;
        if (en_c && ((j_c != pj_c) || (k_c != pk_c))) jk_viol_c <= jk_viol_c + 1;
        pj_c <= j_c;
        pk_c <= k_c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // start is captured at edge N; afterwards the bench sits just past edge N
    task automatic start_at();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    int mm0;
    int en0;
    int viol0;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fault = 2'd0;
        ticks(3);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_step", 32'(step_a), 0);
        chk("rst_jken", 32'({j_a, k_a, en_a, mm_a}), 0);
        rst_n = 1'b1;
        ticks(6);

        // Run 1: good latch; A done at N+36, C done at N+29
        mm0 = mm_cnt_a; en0 = en_cnt_c; viol0 = jk_viol_c;
        start_at();
        tick();                      // N+1
        chk("r1_setup_busy", 32'(busy_a), 1);
        chk("r1_setup_step", 32'(step_a), 0);
        chk("r1_setup_en", 32'(en_a), 0);
        ticks(6);                    // N+7 step 1 ENABLE
        chk("r1_s1_en", 32'({en_a, j_a, k_a}), 32'b100);
        chk("r1_s1_step", 32'(step_a), 1);
        ticks(5);                    // N+12 step 2 ENABLE
        chk("r1_s2_en", 32'({en_a, j_a, k_a}), 32'b110);
        ticks(16);                   // N+28
        chk("r1_c_done_early", 32'(done_c), 0);
        tick();                      // N+29
        chk("r1_c_done", 32'(done_c), 1);
        chk("r1_c_pass", 32'(pass_c), 1);
        chk("r1_c_en_pulses", 32'(en_cnt_c - en0), 5);
        chk("r1_c_jk_stable", 32'(jk_viol_c - viol0), 0);
        ticks(6);                    // N+35
        chk("r1_done_early", 32'(done_a), 0);
        chk("r1_busy_late", 32'(busy_a), 1);
        tick();                      // N+36
        chk("r1_done", 32'(done_a), 1);
        chk("r1_pass", 32'(pass_a), 1);
        chk("r1_err", 32'(err_a), 0);
        chk("r1_busy_end", 32'(busy_a), 0);
        chk("r1_step_end", 32'(step_a), 6);
        chk("r1_jken_end", 32'({j_a, k_a, en_a}), 0);
        chk("r1_no_mismatch", 32'(mm_cnt_a - mm0), 0);

        // Run 2: Q stuck-at-0, restarted from DONE
        fault = 2'd1;
        mm0 = mm_cnt_a;
        start_at();
        tick();                      // N+1
        chk("r2_done_clr", 32'(done_a), 0);
        chk("r2_pass_clr", 32'(pass_a), 0);
        chk("r2_busy", 32'(busy_a), 1);
        ticks(14);                   // N+15 step 2 CHECK
        chk("r2_mm_s2", 32'(mm_a), 1);
        chk("r2_err_s2", 32'(err_a), 1);
        tick();
        chk("r2_mm_pulse", 32'(mm_a), 0);
        ticks(9);                    // N+25 step 4 CHECK
        chk("r2_mm_s4", 32'(mm_a), 1);
        chk("r2_err_s4", 32'(err_a), 2);
        ticks(11);                   // N+36
        chk("r2_done", 32'(done_a), 1);
        chk("r2_pass", 32'(pass_a), 0);
        chk("r2_err", 32'(err_a), 2);
        chk("r2_err_b", 32'(err_b), 2);
        chk("r2_mm_count", 32'(mm_cnt_a - mm0), 2);

        // Run 3: Qn tied to Q; B saturates
        fault = 2'd2;
        mm0 = mm_cnt_a;
        start_at();
        tick();
        chk("r3_err_clr", 32'(err_a), 0);
        chk("r3_done_clr", 32'(done_a), 0);
        ticks(35);                   // N+36
        chk("r3_done", 32'(done_a), 1);
        chk("r3_pass", 32'(pass_a), 0);
        chk("r3_err", 32'(err_a), 5);
        chk("r3_err_sat_b", 32'(err_b), 3);
        chk("r3_mm_count", 32'(mm_cnt_a - mm0), 5);

        // Run 4: reset during step 3 SETTLE, then a clean rerun
        start_at();
        ticks(18);                   // N+18
        chk("r4_pre_step", 32'(step_a), 3);
        chk("r4_pre_err", 32'(err_a), 1);
        chk("r4_pre_k", 32'({j_a, k_a}), 1);
        rst_n = 1'b0;
        tick();
        chk("r4_rst_flags", 32'({busy_a, done_a, pass_a, mm_a}), 0);
        chk("r4_rst_jken", 32'({j_a, k_a, en_a}), 0);
        chk("r4_rst_step", 32'(step_a), 0);
        chk("r4_rst_err", 32'(err_a), 0);
        rst_n = 1'b1;
        fault = 2'd0;
        tick();
        chk("r4_idle", 32'({busy_a, done_a}), 0);
        start_at();
        ticks(36);
        chk("r4_done", 32'(done_a), 1);
        chk("r4_pass", 32'(pass_a), 1);
        chk("r4_err", 32'(err_a), 0);

        // Run 5: start while busy is ignored
        start_at();
        ticks(21);                   // N+21 step 4 SETUP
        start = 1'b1;
        tick();                      // N+22
        start = 1'b0;
        chk("r5_step", 32'(step_a), 4);
        ticks(13);                   // N+35
        chk("r5_done_early", 32'(done_a), 0);
        tick();                      // N+36
        chk("r5_done", 32'(done_a), 1);
        chk("r5_pass", 32'(pass_a), 1);
        chk("r5_step_end", 32'(step_a), 6);
        ticks(3);
        chk("r5_stays_done", 32'({done_a, busy_a}), 32'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
